// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus bundle for mem_arbiter: icache and dcache request ports plus the RAM port.
// slave is the arbiter's view; master is the surrounding system (caches and RAM model).
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        arb_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) single-RAM arbiter, one word per grant, sticky fault on RAM error or busy timeout.
// Define MEM_ARBITER_STATS_EN to add the icount/dcount completed-transfer counters.
module mem_arbiter #(
    parameter int unsigned BUSY_LIMIT = 255
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]   icount,
    output logic [31:0]   dcount
`endif
);

    localparam int CNT_W = (BUSY_LIMIT > 255) ? $clog2(BUSY_LIMIT + 1) : 8;

    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, FAULT} state_t;

    state_t           state, state_nx;
    logic             last_grant, last_grant_nx;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_nx;
    logic             d_req;

    assign d_req = bus.dREN | bus.dWEN;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            busy_cnt   <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            busy_cnt   <= busy_cnt_nx;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        busy_cnt_nx   = busy_cnt;
        bus.iwait     = 1'b1;
        bus.iload     = '0;
        bus.dwait     = 1'b1;
        bus.dload     = '0;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;
        bus.arb_err   = 1'b0;

        unique case (state)
            IDLE: begin
                busy_cnt_nx = '0;
                // D loses only when it just had the bus and I is waiting.
                if (d_req && !(last_grant == GRANT_D && bus.iREN)) begin
                    state_nx = DGRANT;
                end else if (bus.iREN) begin
                    state_nx = IGRANT;
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    state_nx = IDLE;
                end else begin
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = ~bus.dWEN;
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    if (bus.ramstate == RS_ERROR) begin
                        state_nx = FAULT;
                    end else if (bus.ramstate == RS_ACCESS) begin
                        bus.dwait     = 1'b0;
                        bus.dload     = bus.dWEN ? '0 : bus.ramload;
                        state_nx      = IDLE;
                        last_grant_nx = GRANT_D;
                    end else if (bus.ramstate == RS_BUSY) begin
                        if (busy_cnt == CNT_W'(BUSY_LIMIT - 1)) state_nx = FAULT;
                        else busy_cnt_nx = busy_cnt + CNT_W'(1);
                    end
                end
            end

            IGRANT: begin
                if (!bus.iREN) begin
                    state_nx = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == RS_ERROR) begin
                        state_nx = FAULT;
                    end else if (bus.ramstate == RS_ACCESS) begin
                        bus.iwait     = 1'b0;
                        bus.iload     = bus.ramload;
                        state_nx      = IDLE;
                        last_grant_nx = GRANT_I;
                    end else if (bus.ramstate == RS_BUSY) begin
                        if (busy_cnt == CNT_W'(BUSY_LIMIT - 1)) state_nx = FAULT;
                        else busy_cnt_nx = busy_cnt + CNT_W'(1);
                    end
                end
            end

            FAULT: begin
                bus.arb_err = 1'b1;
            end

            default: state_nx = FAULT;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    logic d_done, i_done;

    assign d_done = (state == DGRANT) && d_req    && (bus.ramstate == RS_ACCESS);
    assign i_done = (state == IGRANT) && bus.iREN && (bus.ramstate == RS_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (i_done) icount <= icount + 32'd1;
            if (d_done) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 255;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam int OWN_NONE = 0, OWN_D = 1, OWN_I = 2, OWN_DEAD = 3;

    typedef struct packed {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rs;
    } in_t;

    typedef struct packed {
        logic        iwait;
        logic [31:0] iload;
        logic        dwait;
        logic [31:0] dload;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] icount, dcount;
`endif

    mem_arbiter #(.BUSY_LIMIT(LIMIT)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .icount (icount),
        .dcount (dcount)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the RAM, whose turn it is, and how long the current grant has waited.
    int          m_owner, n_owner;
    bit          m_last_d, n_last_d;
    int          m_busy, n_busy;
    logic [31:0] m_icnt, n_icnt, m_dcnt, n_dcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(logic iren, logic [31:0] iaddr, logic dren, logic dwen,
                                  logic [31:0] daddr, logic [31:0] dstore,
                                  logic [31:0] ramload, logic [1:0] rs);
        in_t v;
        v.iren = iren;   v.iaddr = iaddr;   v.dren = dren;       v.dwen = dwen;
        v.daddr = daddr; v.dstore = dstore; v.ramload = ramload; v.rs = rs;
        return v;
    endfunction

    function automatic out_t mk_out(logic iwait, logic [31:0] iload, logic dwait,
                                    logic [31:0] dload, logic ren, logic wen,
                                    logic [31:0] addr, logic [31:0] store, logic err);
        out_t v;
        v.iwait = iwait; v.iload = iload; v.dwait = dwait; v.dload = dload;
        v.ren = ren;     v.wen = wen;     v.addr = addr;   v.store = store; v.err = err;
        return v;
    endfunction

    function automatic out_t idle_out();
        return mk_out(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endfunction

    function automatic vec_t mkv(in_t i, out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        return v;
    endfunction

    task automatic apply(input in_t v);
        bus.iREN = v.iren;   bus.iaddr = v.iaddr;   bus.dREN = v.dren;       bus.dWEN = v.dwen;
        bus.daddr = v.daddr; bus.dstore = v.dstore; bus.ramload = v.ramload; bus.ramstate = v.rs;
    endtask

    function automatic out_t read_dut();
        return mk_out(bus.iwait, bus.iload, bus.dwait, bus.dload, bus.ramREN, bus.ramWEN,
                      bus.ramaddr, bus.ramstore, bus.arb_err);
    endfunction

    task automatic compare_all(input string tag, input out_t e);
        out_t a;
        a = read_dut();
        check({tag, ".iwait"},    a.iwait, e.iwait);
        check({tag, ".iload"},    a.iload, e.iload);
        check({tag, ".dwait"},    a.dwait, e.dwait);
        check({tag, ".dload"},    a.dload, e.dload);
        check({tag, ".ramREN"},   a.ren,   e.ren);
        check({tag, ".ramWEN"},   a.wen,   e.wen);
        check({tag, ".ramaddr"},  a.addr,  e.addr);
        check({tag, ".ramstore"}, a.store, e.store);
        check({tag, ".arb_err"},  a.err,   e.err);
`ifdef MEM_ARBITER_STATS_EN
        check({tag, ".icount"},   icount,  m_icnt);
        check({tag, ".dcount"},   dcount,  m_dcnt);
`endif
    endtask

    task automatic model_reset();
        m_owner = OWN_NONE; m_last_d = 1'b0; m_busy = 0; m_icnt = '0; m_dcnt = '0;
    endtask

    // Expected outputs for this cycle from the current inputs, plus the ownership after the edge.
    task automatic model_predict(output out_t e);
        bit dq, is_d, want;
        e = idle_out();
        n_owner = m_owner; n_last_d = m_last_d; n_busy = m_busy; n_icnt = m_icnt; n_dcnt = m_dcnt;
        dq = bus.dREN | bus.dWEN;
        if (m_owner == OWN_DEAD) begin
            e.err = 1'b1;
        end else if (m_owner == OWN_NONE) begin
            if (dq && !(m_last_d && bus.iREN)) begin
                n_owner = OWN_D; n_busy = 0;
            end else if (bus.iREN) begin
                n_owner = OWN_I; n_busy = 0;
            end
        end else begin
            is_d = (m_owner == OWN_D);
            want = is_d ? dq : bus.iREN;
            if (!want) begin
                n_owner = OWN_NONE;
            end else begin
                e.addr  = is_d ? bus.daddr : bus.iaddr;
                e.store = is_d ? bus.dstore : 32'h0;
                e.wen   = is_d & bus.dWEN;
                e.ren   = is_d ? ~bus.dWEN : 1'b1;
                case (bus.ramstate)
                    ERROR: n_owner = OWN_DEAD;
                    ACCESS: begin
                        n_owner  = OWN_NONE;
                        n_last_d = is_d;
                        if (is_d) begin
                            e.dwait = 1'b0;
                            e.dload = bus.dWEN ? 32'h0 : bus.ramload;
                            n_dcnt  = m_dcnt + 32'd1;
                        end else begin
                            e.iwait = 1'b0;
                            e.iload = bus.ramload;
                            n_icnt  = m_icnt + 32'd1;
                        end
                    end
                    BUSY: begin
                        n_busy = m_busy + 1;
                        if (n_busy >= LIMIT) n_owner = OWN_DEAD;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_commit();
        m_owner = n_owner; m_last_d = n_last_d; m_busy = n_busy; m_icnt = n_icnt; m_dcnt = n_dcnt;
    endtask

    // One clock: compare at the falling edge, advance model at the rising edge, return at +1.
    task automatic tick(input string tag, output out_t seen);
        out_t e;
        @(negedge clk);
        model_predict(e);
        seen = read_dut();
        compare_all(tag, e);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic tbl_tick(input string tag, input out_t exp);
        out_t e;
        @(negedge clk);
        model_predict(e);
        compare_all(tag, exp);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, FREE));
        #1;
        model_reset();
        compare_all("reset", idle_out());
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    vec_t  tbl [16];
    out_t  seen;
    string order;
    int    r;

    initial begin
        tbl[0]  = mkv(mk_in(0, 0, 1, 0, 32'h40, 0, 0, FREE), idle_out());
        tbl[1]  = mkv(mk_in(0, 0, 1, 0, 32'h40, 0, 0, BUSY), mk_out(1, 0, 1, 0, 1, 0, 32'h40, 0, 0));
        tbl[2]  = mkv(mk_in(0, 0, 1, 0, 32'h40, 0, 0, BUSY), mk_out(1, 0, 1, 0, 1, 0, 32'h40, 0, 0));
        tbl[3]  = mkv(mk_in(0, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF, ACCESS),
                      mk_out(1, 0, 0, 32'hDEADBEEF, 1, 0, 32'h40, 0, 0));
        tbl[4]  = mkv(mk_in(0, 0, 0, 0, 0, 0, 0, FREE), idle_out());
        tbl[5]  = mkv(mk_in(0, 0, 1, 1, 32'h3100, 32'h5, 0, FREE), idle_out());
        tbl[6]  = mkv(mk_in(0, 0, 1, 1, 32'h3100, 32'h5, 32'h12345678, ACCESS),
                      mk_out(1, 0, 0, 0, 0, 1, 32'h3100, 32'h5, 0));
        tbl[7]  = mkv(mk_in(0, 0, 0, 0, 0, 0, 0, FREE), idle_out());
        tbl[8]  = mkv(mk_in(1, 32'h80, 0, 0, 0, 0, 0, FREE), idle_out());
        tbl[9]  = mkv(mk_in(1, 32'h80, 0, 0, 0, 0, 32'hCAFEF00D, ACCESS),
                      mk_out(0, 32'hCAFEF00D, 1, 0, 1, 0, 32'h80, 0, 0));
        tbl[10] = mkv(mk_in(0, 0, 0, 0, 0, 0, 0, FREE), idle_out());
        tbl[11] = mkv(mk_in(1, 32'h84, 1, 0, 32'h44, 32'h99, 0, FREE), idle_out());
        tbl[12] = mkv(mk_in(1, 32'h84, 1, 0, 32'h44, 32'h99, 32'h11, ACCESS),
                      mk_out(1, 0, 0, 32'h11, 1, 0, 32'h44, 32'h99, 0));
        tbl[13] = mkv(mk_in(1, 32'h84, 1, 0, 32'h44, 32'h99, 0, FREE), idle_out());
        tbl[14] = mkv(mk_in(1, 32'h84, 1, 0, 32'h44, 32'h99, 32'h22, ACCESS),
                      mk_out(0, 32'h22, 1, 0, 1, 0, 32'h84, 0, 0));
        tbl[15] = mkv(mk_in(0, 0, 0, 0, 0, 0, 0, FREE), idle_out());

        #2;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].i);
            tbl_tick($sformatf("vec%0d", k), tbl[k].o);
        end

        // Both ports requesting every cycle must alternate D,I,D,I.
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dWEN = 1'b1; bus.daddr = 32'h200;
        bus.ramstate = ACCESS;
        order = "";
        for (int c = 0; c < 8; c++) begin
            bus.dstore = 32'h1000 + 32'(c);
            tick("alt", seen);
            if (!seen.dwait) begin
                order = {order, "D"};
                check("alt.d_wen", seen.wen, 1'b1);
                check("alt.d_store", seen.store, 32'h1000 + 32'(c));
            end
            if (!seen.iwait) order = {order, "I"};
        end
        n_cmp++;
        if (order != "DIDI") begin
            n_err++;
            $display("FAIL alt.order: got %s expected DIDI", order);
        end

        // Dropping the request mid-BUSY releases the RAM combinationally, with no completion.
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h70; bus.ramstate = BUSY;
        tick("drop0", seen);
        tick("drop1", seen);
        check("drop1.ren", seen.ren, 1'b1);
        bus.dREN = 1'b0;
        tick("drop2", seen);
        check("drop2.ren", seen.ren, 1'b0);
        check("drop2.dwait", seen.dwait, 1'b1);
        bus.ramstate = ACCESS;
        tick("drop3", seen);
        check("drop3.dwait", seen.dwait, 1'b1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = BUSY;
        tick("arst0", seen);
        tick("arst1", seen);
        #2;
        nrst = 1'b0;
        #1;
        compare_all("arst.async", idle_out());
        model_reset();
        bus.dREN = 1'b0;
        bus.ramstate = ACCESS;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick("arst.after", seen);
            check("arst.after.dwait", seen.dwait, 1'b1);
        end

        // RAM ERROR during a grant is sticky.
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h60; bus.ramstate = FREE;
        tick("err0", seen);
        bus.ramstate = ERROR;
        tick("err1", seen);
        check("err1.err", seen.err, 1'b0);
        bus.ramstate = ACCESS;
        tick("err2", seen);
        check("err2.err", seen.err, 1'b1);
        check("err2.dwait", seen.dwait, 1'b1);
        check("err2.ren", seen.ren, 1'b0);

        // Busy timeout: the 255th consecutive BUSY cycle is the last one granted.
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = BUSY;
        tick("lim.idle", seen);
        for (int c = 1; c <= 255; c++) tick("lim.busy", seen);
        check("lim.last.err", seen.err, 1'b0);
        check("lim.last.ren", seen.ren, 1'b1);
        tick("lim.fault", seen);
        check("lim.fault.err", seen.err, 1'b1);
        check("lim.fault.iwait", seen.iwait, 1'b1);
        check("lim.fault.ren", seen.ren, 1'b0);
        bus.ramstate = ACCESS;
        for (int c = 0; c < 4; c++) begin
            tick("lim.stuck", seen);
            check("lim.stuck.iwait", seen.iwait, 1'b1);
        end

        // Three D completions then two I completions.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(mk_in(0, 0, 1, 0, 32'h500 + 32'(c), 0, 32'hA0 + 32'(c), FREE));
            tick("cnt.d", seen);
            bus.ramstate = ACCESS;
            tick("cnt.d", seen);
            bus.dREN = 1'b0;
            tick("cnt.d", seen);
        end
        for (int c = 0; c < 2; c++) begin
            apply(mk_in(1, 32'h600 + 32'(c), 0, 0, 0, 0, 32'hB0 + 32'(c), FREE));
            tick("cnt.i", seen);
            bus.ramstate = ACCESS;
            tick("cnt.i", seen);
            bus.iREN = 1'b0;
            tick("cnt.i", seen);
        end
`ifdef MEM_ARBITER_STATS_EN
        check("cnt.dcount", dcount, 32'd3);
        check("cnt.icount", icount, 32'd2);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(3) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(5) == 0) bus.dWEN = ~bus.dWEN;
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            r = int'($urandom_range(9));
            bus.ramstate = (r < 3) ? FREE : (r < 7) ? BUSY : ACCESS;
            tick("rand", seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
